// File: rtl/irrigation_sequencer_if.sv
// Irrigation sequencer bus: sensor/tick inputs and registered valve,
// alarm and status outputs.
//   slave  : sequencer side (samples sensors, drives outputs)
//   master : environment side (drives sensors and tick, observes outputs)
interface irrigation_sequencer_if;
  logic       tick_1s;
  logic       H;
  logic       M;
  logic       L;
  logic       Ua;
  logic       Us;
  logic       T;
  logic       Ve;
  logic       Bs;
  logic       Vs;
  logic       Alarme;
  logic       Erro;
  logic [2:0] estado;
  logic [7:0] tempo;

  modport slave (
    input  tick_1s, H, M, L, Ua, Us, T,
    output Ve, Bs, Vs, Alarme, Erro, estado, tempo
  );

  modport master (
    output tick_1s, H, M, L, Ua, Us, T,
    input  Ve, Bs, Vs, Alarme, Erro, estado, tempo
  );
endinterface

// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: chooses drip or sprayer irrigation from soil/air/
// temperature sensors, bounds each cycle between MIN_ON and MAX_ON seconds,
// rests COOL seconds afterwards, runs the tank inlet valve with H/M
// hysteresis and latches a sticky fault on an impossible level pattern.
// Ports:
//   clk       : system clock
//   reiniciar : asynchronous active-low reset
//   bus       : sensors + tick_1s in, Ve/Bs/Vs/Alarme/Erro/estado/tempo out
//
// state    | meaning
// IDLE     | waiting for demand (dry soil and water in tank)
// DRIP     | drip valve open
// SPRAY    | sprinkler valve open
// COOLDOWN | rest period after any irrigation cycle
// FAULT    | level probes inconsistent; all valves closed until reset
module irrigation_sequencer #(
  parameter int DEBOUNCE = 3,
  parameter int MIN_ON   = 10,
  parameter int MAX_ON   = 60,
  parameter int COOL     = 5
) (
  input  logic                 clk,
  input  logic                 reiniciar,
  irrigation_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRIP     = 3'd1,
    ST_SPRAY    = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [3:0] DEBOUNCE_C = 4'(DEBOUNCE);
  localparam logic [7:0] MIN_ON_C   = 8'(MIN_ON);
  localparam logic [7:0] MAX_ON_C   = 8'(MAX_ON);
  localparam logic [7:0] COOL_LAST  = 8'(COOL - 1);

  // Synchronizers, bit order {H, M, L, Ua, Us, T}
  logic [5:0] sync1_q, sync2_q;
  logic       sH, sM, sL, sUa, sUs, sT;

  state_t     state_q, state_d;
  logic [7:0] tempo_q, tempo_d;
  logic [3:0] inv_cnt_q, inv_cnt_d;
  logic       ve_q, ve_d;
  logic       bs_q, vs_q, alarme_q, erro_q;

  logic       invalid, fault, demand, drip_mode;

  assign {sH, sM, sL, sUa, sUs, sT} = sync2_q;

  assign invalid   = (sH & ~sM) | (sM & ~sL);
  assign fault     = (inv_cnt_q >= DEBOUNCE_C);
  assign demand    = ~sUs & sL;
  assign drip_mode = sT | ~sUa;

  always_comb begin
    inv_cnt_d = inv_cnt_q;
    if (bus.tick_1s) begin
      if (!invalid)               inv_cnt_d = 4'd0;
      else if (inv_cnt_q != 4'hF) inv_cnt_d = inv_cnt_q + 4'd1;
    end
  end

  // Mode is fixed by the IDLE exit target; DRIP/SPRAY never swap mid-cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fault)       state_d = ST_FAULT;
        else if (demand) state_d = drip_mode ? ST_DRIP : ST_SPRAY;
      end
      ST_DRIP, ST_SPRAY: begin
        if (fault)                              state_d = ST_FAULT;
        else if (!sL)                           state_d = ST_COOLDOWN;
        else if (tempo_q >= MAX_ON_C)           state_d = ST_COOLDOWN;
        else if (tempo_q >= MIN_ON_C && !demand) state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (fault)                                    state_d = ST_FAULT;
        else if (bus.tick_1s && tempo_q >= COOL_LAST) state_d = ST_IDLE;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tempo_d = tempo_q;
    if (state_d != state_q)                tempo_d = 8'd0;
    else if (bus.tick_1s && tempo_q != 8'hFF) tempo_d = tempo_q + 8'd1;
  end

  // Inlet hysteresis: H full stops filling, losing M starts filling.
  always_comb begin
    ve_d = ve_q;
    if (state_d == ST_FAULT) ve_d = 1'b0;
    else if (sH)             ve_d = 1'b0;
    else if (!sM)            ve_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reiniciar) begin
    if (!reiniciar) begin
      sync1_q   <= 6'd0;
      sync2_q   <= 6'd0;
      state_q   <= ST_IDLE;
      tempo_q   <= 8'd0;
      inv_cnt_q <= 4'd0;
      ve_q      <= 1'b0;
      bs_q      <= 1'b0;
      vs_q      <= 1'b0;
      alarme_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      sync1_q   <= {bus.H, bus.M, bus.L, bus.Ua, bus.Us, bus.T};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      tempo_q   <= tempo_d;
      inv_cnt_q <= inv_cnt_d;
      ve_q      <= ve_d;
      // Outputs decoded from next state so they change with the state register.
      bs_q      <= (state_d == ST_SPRAY);
      vs_q      <= (state_d == ST_DRIP);
      alarme_q  <= ~sL & (state_d != ST_FAULT);
      erro_q    <= (state_d == ST_FAULT);
    end
  end

  assign bus.Ve     = ve_q;
  assign bus.Bs     = bs_q;
  assign bus.Vs     = vs_q;
  assign bus.Alarme = alarme_q;
  assign bus.Erro   = erro_q;
  assign bus.estado = state_q;
  assign bus.tempo  = tempo_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
module tb_irrigation_sequencer;
  logic clk = 1'b0;
  logic reiniciar;
  int   checks = 0;
  int   errors = 0;

  irrigation_sequencer_if bus();

  irrigation_sequencer #(
    .DEBOUNCE(3), .MIN_ON(10), .MAX_ON(60), .COOL(5)
  ) dut (
    .clk       (clk),
    .reiniciar (reiniciar),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.tick_1s = 1'b1;
      @(negedge clk) bus.tick_1s = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reiniciar = 1'b0;
    bus.tick_1s = 1'b0;
    bus.H = 1'b1; bus.M = 1'b1; bus.L = 1'b1;
    bus.Ua = 1'b1; bus.Us = 1'b1; bus.T = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.estado !== 3'd0) begin errors++; $display("FAIL rst_estado got %0d want 0", bus.estado); end
    checks++; if (bus.tempo !== 8'd0) begin errors++; $display("FAIL rst_tempo got %0d want 0", bus.tempo); end
    checks++; if ({bus.Ve, bus.Bs, bus.Vs, bus.Alarme, bus.Erro} !== 5'b0) begin errors++;
      $display("FAIL rst_outputs got %b want 00000", {bus.Ve, bus.Bs, bus.Vs, bus.Alarme, bus.Erro}); end
    @(negedge clk) reiniciar = 1'b1;
    settle();
    checks++; if (bus.estado !== 3'd0) begin errors++; $display("FAIL rel_estado got %0d want 0", bus.estado); end
    checks++; if ({bus.Ve, bus.Alarme, bus.Erro} !== 3'b0) begin errors++;
      $display("FAIL rel_outputs got %b want 000", {bus.Ve, bus.Alarme, bus.Erro}); end
  endtask

  task automatic test_drip();
    @(negedge clk) begin bus.Us = 1'b0; bus.T = 1'b1; end
    settle();
    checks++; if (bus.estado !== 3'd1) begin errors++; $display("FAIL drip_enter got %0d want 1", bus.estado); end
    checks++; if ({bus.Vs, bus.Bs} !== 2'b10) begin errors++; $display("FAIL drip_valves got %b want 10", {bus.Vs, bus.Bs}); end
    checks++; if (bus.tempo !== 8'd0) begin errors++; $display("FAIL drip_tempo0 got %0d want 0", bus.tempo); end
    for (int i = 1; i <= 10; i++) begin
      tick_n(1);
      checks++; if (bus.estado !== 3'd1 || bus.Vs !== 1'b1) begin errors++;
        $display("FAIL drip_hold tick %0d got estado %0d Vs %b want 1 1", i, bus.estado, bus.Vs); end
    end
    checks++; if (bus.tempo !== 8'd10) begin errors++; $display("FAIL drip_tempo10 got %0d want 10", bus.tempo); end
    @(negedge clk) bus.Us = 1'b1;
    settle();
    checks++; if (bus.estado !== 3'd3 || bus.Vs !== 1'b0) begin errors++;
      $display("FAIL drip_to_cool got estado %0d Vs %b want 3 0", bus.estado, bus.Vs); end
    checks++; if (bus.tempo !== 8'd0) begin errors++; $display("FAIL cool_tempo0 got %0d want 0", bus.tempo); end
    for (int i = 1; i <= 4; i++) begin
      tick_n(1);
      checks++; if (bus.estado !== 3'd3) begin errors++; $display("FAIL cool_hold tick %0d got %0d want 3", i, bus.estado); end
    end
    tick_n(1);
    checks++; if (bus.estado !== 3'd0) begin errors++; $display("FAIL cool_exit got %0d want 0", bus.estado); end
  endtask

  task automatic test_min_on();
    @(negedge clk) begin bus.Us = 1'b0; bus.T = 1'b1; end
    settle();
    tick_n(3);
    @(negedge clk) bus.Us = 1'b1;
    settle();
    checks++; if (bus.estado !== 3'd1) begin errors++; $display("FAIL minon_hold got %0d want 1", bus.estado); end
    tick_n(6);
    checks++; if (bus.estado !== 3'd1 || bus.tempo !== 8'd9) begin errors++;
      $display("FAIL minon_t9 got estado %0d tempo %0d want 1 9", bus.estado, bus.tempo); end
    tick_n(1);
    checks++; if (bus.estado !== 3'd3) begin errors++; $display("FAIL minon_release got %0d want 3", bus.estado); end
    tick_n(5);
    checks++; if (bus.estado !== 3'd0) begin errors++; $display("FAIL minon_idle got %0d want 0", bus.estado); end
  endtask

  task automatic test_spray_max();
    @(negedge clk) begin bus.Us = 1'b0; bus.Ua = 1'b1; bus.T = 1'b0; end
    settle();
    checks++; if (bus.estado !== 3'd2 || {bus.Bs, bus.Vs} !== 2'b10) begin errors++;
      $display("FAIL spray_enter got estado %0d BsVs %b want 2 10", bus.estado, {bus.Bs, bus.Vs}); end
    for (int i = 1; i <= 59; i++) begin
      tick_n(1);
      checks++; if (bus.estado !== 3'd2 || bus.Bs !== 1'b1) begin errors++;
        $display("FAIL spray_hold tick %0d got estado %0d Bs %b want 2 1", i, bus.estado, bus.Bs); end
    end
    checks++; if (bus.tempo !== 8'd59) begin errors++; $display("FAIL spray_t59 got %0d want 59", bus.tempo); end
    tick_n(1);
    checks++; if (bus.estado !== 3'd3 || bus.Bs !== 1'b0) begin errors++;
      $display("FAIL spray_max got estado %0d Bs %b want 3 0", bus.estado, bus.Bs); end
    tick_n(4);
    checks++; if (bus.estado !== 3'd3) begin errors++; $display("FAIL spray_cool got %0d want 3", bus.estado); end
    tick_n(1);
    checks++; if (bus.estado !== 3'd2 || bus.Bs !== 1'b1) begin errors++;
      $display("FAIL spray_reenter got estado %0d Bs %b want 2 1", bus.estado, bus.Bs); end
  endtask

  task automatic test_async_reset();
    tick_n(3);
    checks++; if (bus.tempo !== 8'd3) begin errors++; $display("FAIL areset_pre got %0d want 3", bus.tempo); end
    @(negedge clk);
    #2 reiniciar = 1'b0;
    #1;
    checks++; if (bus.Bs !== 1'b0 || bus.Vs !== 1'b0) begin errors++;
      $display("FAIL areset_valves got BsVs %b want 00", {bus.Bs, bus.Vs}); end
    checks++; if (bus.estado !== 3'd0 || bus.tempo !== 8'd0) begin errors++;
      $display("FAIL areset_state got estado %0d tempo %0d want 0 0", bus.estado, bus.tempo); end
    bus.Us = 1'b1;
    @(negedge clk) reiniciar = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (bus.estado !== 3'd0 || bus.Bs !== 1'b0 || bus.Alarme !== 1'b0) begin errors++;
      $display("FAIL areset_release got estado %0d Bs %b Alarme %b want 0 0 0", bus.estado, bus.Bs, bus.Alarme); end
  endtask

  task automatic test_empty();
    @(negedge clk) begin bus.Us = 1'b0; bus.T = 1'b1; end
    settle();
    tick_n(4);
    checks++; if (bus.estado !== 3'd1 || bus.tempo !== 8'd4) begin errors++;
      $display("FAIL empty_pre got estado %0d tempo %0d want 1 4", bus.estado, bus.tempo); end
    bus.H = 1'b0; bus.M = 1'b0; bus.L = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.Vs !== 1'b1) begin errors++; $display("FAIL empty_latency got Vs %b want 1", bus.Vs); end
    @(negedge clk);
    checks++; if (bus.Vs !== 1'b0 || bus.Alarme !== 1'b1) begin errors++;
      $display("FAIL empty_react got Vs %b Alarme %b want 0 1", bus.Vs, bus.Alarme); end
    checks++; if (bus.estado !== 3'd3 || bus.Ve !== 1'b1) begin errors++;
      $display("FAIL empty_state got estado %0d Ve %b want 3 1", bus.estado, bus.Ve); end
    bus.Us = 1'b1;
    tick_n(5);
    checks++; if (bus.estado !== 3'd0 || bus.Alarme !== 1'b1) begin errors++;
      $display("FAIL empty_idle got estado %0d Alarme %b want 0 1", bus.estado, bus.Alarme); end
  endtask

  task automatic test_ve_hysteresis();
    @(negedge clk) bus.L = 1'b1;
    settle();
    checks++; if (bus.Ve !== 1'b1 || bus.Alarme !== 1'b0) begin errors++;
      $display("FAIL ve_lonly got Ve %b Alarme %b want 1 0", bus.Ve, bus.Alarme); end
    @(negedge clk) bus.M = 1'b1;
    settle();
    checks++; if (bus.Ve !== 1'b1) begin errors++; $display("FAIL ve_mraise got %b want 1", bus.Ve); end
    @(negedge clk) bus.H = 1'b1;
    settle();
    checks++; if (bus.Ve !== 1'b0) begin errors++; $display("FAIL ve_hraise got %b want 0", bus.Ve); end
    @(negedge clk) bus.H = 1'b0;
    settle();
    checks++; if (bus.Ve !== 1'b0) begin errors++; $display("FAIL ve_hdrop got %b want 0", bus.Ve); end
    @(negedge clk) bus.M = 1'b0;
    settle();
    checks++; if (bus.Ve !== 1'b1) begin errors++; $display("FAIL ve_mdrop got %b want 1", bus.Ve); end
  endtask

  task automatic test_fault();
    @(negedge clk) begin bus.Us = 1'b1; bus.H = 1'b1; bus.M = 1'b0; bus.L = 1'b1; end
    settle();
    tick_n(2);
    checks++; if (bus.Erro !== 1'b0) begin errors++; $display("FAIL fault_two got Erro %b want 0", bus.Erro); end
    @(negedge clk) begin bus.H = 1'b1; bus.M = 1'b1; bus.L = 1'b1; end
    settle();
    tick_n(1);
    checks++; if (bus.Erro !== 1'b0 || bus.estado !== 3'd0) begin errors++;
      $display("FAIL fault_cleared got Erro %b estado %0d want 0 0", bus.Erro, bus.estado); end
    @(negedge clk) bus.M = 1'b0;
    settle();
    tick_n(2);
    checks++; if (bus.Erro !== 1'b0) begin errors++; $display("FAIL fault_recount got Erro %b want 0", bus.Erro); end
    tick_n(1);
    checks++; if (bus.Erro !== 1'b1 || bus.estado !== 3'd4) begin errors++;
      $display("FAIL fault_set got Erro %b estado %0d want 1 4", bus.Erro, bus.estado); end
    checks++; if ({bus.Ve, bus.Bs, bus.Vs} !== 3'b000) begin errors++;
      $display("FAIL fault_valves got %b want 000", {bus.Ve, bus.Bs, bus.Vs}); end
    @(negedge clk) begin bus.M = 1'b1; bus.Us = 1'b0; end
    settle();
    tick_n(3);
    checks++; if (bus.Erro !== 1'b1 || bus.estado !== 3'd4 || {bus.Bs, bus.Vs} !== 2'b00) begin errors++;
      $display("FAIL fault_sticky got Erro %b estado %0d BsVs %b want 1 4 00", bus.Erro, bus.estado, {bus.Bs, bus.Vs}); end
    @(negedge clk) begin reiniciar = 1'b0; bus.Us = 1'b1; end
    @(negedge clk);
    checks++; if (bus.Erro !== 1'b0 || bus.estado !== 3'd0) begin errors++;
      $display("FAIL fault_reset got Erro %b estado %0d want 0 0", bus.Erro, bus.estado); end
    reiniciar = 1'b1;
    settle();
    checks++; if (bus.Erro !== 1'b0 || bus.estado !== 3'd0) begin errors++;
      $display("FAIL fault_after got Erro %b estado %0d want 0 0", bus.Erro, bus.estado); end
  endtask

  initial begin
    test_reset();
    test_drip();
    test_min_on();
    test_spray_max();
    test_async_reset();
    test_empty();
    test_ve_hysteresis();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter: DEBOUNCE, 3, consecutive tick_1s samples of invalid level pattern before fault is declared (1..15).
REQ-002 Parameter: MIN_ON, 10, minimum irrigation on-time in seconds (1..MAX_ON).
REQ-003 Parameter: MAX_ON, 60, maximum irrigation on-time in seconds (MIN_ON..255).
REQ-004 Parameter: COOL, 5, rest time in seconds after any irrigation cycle (1..255).
REQ-005 Port: clk  input  1  system clock, single clock domain.
REQ-006 Port: reiniciar  input  1  reset, asynchronous, active-low.
REQ-007 Port: tick_1s  input  1  one-clk-wide enable pulse, once per second, synchronous to clk.
REQ-008 Port: H, M, L  input  1 each  tank level probes (high/medium/low), asynchronous, 1 = water at probe.
REQ-009 Port: Ua, Us, T  input  1 each  air humidity (1 = humid), soil humidity (1 = wet), temperature (1 = hot); asynchronous.
REQ-010 Port: Ve  output  1  tank inlet valve.
REQ-011 Port: Bs  output  1  sprinkler valve.
REQ-012 Port: Vs  output  1  drip valve.
REQ-013 Port: Alarme  output  1  tank empty alarm.
REQ-014 Port: Erro  output  1  sensor fault.
REQ-015 Port: estado  output  3  current FSM state code.
REQ-016 Port: tempo  output  8  seconds elapsed in current state, saturating at 255.

Function
REQ-017 All six sensor inputs SHALL pass through a 2-flop synchronizer; all logic uses synchronized values (sH, sM, sL, sUa, sUs, sT).
REQ-018 All outputs SHALL be registered; combinational sensor-to-output paths are forbidden.
REQ-019 Invalid level pattern: (sH & ~sM) | (sM & ~sL); a 4-bit counter increments on each tick_1s with pattern invalid, clears on any tick_1s with pattern valid.
REQ-020 Fault condition: invalid counter reaches DEBOUNCE.
REQ-021 Demand: sUs = 0 & sL = 1; mode DRIP if sT = 1 or sUa = 0, else SPRAY; mode is latched on IDLE exit and is not re-evaluated during the cycle.
REQ-022 States/codes: IDLE=0, DRIP=1, SPRAY=2, COOLDOWN=3, FAULT=4; codes 5-7 unreachable, recover to IDLE.
REQ-023 IDLE -> DRIP/SPRAY on demand; IDLE -> FAULT on fault condition.
REQ-024 DRIP/SPRAY -> FAULT on fault condition; else -> COOLDOWN when sL = 0 (immediate, ignores MIN_ON); else -> COOLDOWN when tempo >= MAX_ON; else -> COOLDOWN when tempo >= MIN_ON and demand = 0.
REQ-025 COOLDOWN -> FAULT on fault condition; else -> IDLE on the tick_1s where tempo reaches COOL.
REQ-026 FAULT is sticky; exit only through reiniciar.
REQ-027 Priority for simultaneous events: fault > empty (sL = 0) > MAX_ON > demand release.
REQ-028 tempo clears to 0 on every state change; otherwise increments on tick_1s, saturating at 255.
REQ-029 Vs = 1 only in DRIP; Bs = 1 only in SPRAY; Vs and Bs are never 1 together.
REQ-030 Ve hysteresis: set when sM = 0, cleared when sH = 1, otherwise holds; forced 0 in FAULT.
REQ-031 Alarme = 1 when sL = 0 and state != FAULT.
REQ-032 Erro = 1 exactly when state = FAULT.
REQ-033 Untimed reaction latency: sensor edge to registered output change in 3 clk (2 sync + 1 output register).

Reset
REQ-034 While reiniciar = 0: state IDLE, tempo 0, invalid counter 0, synchronizers 0, and Ve, Bs, Vs, Alarme, Erro, estado all 0.
REQ-035 Asserting reiniciar mid-irrigation SHALL close Bs/Vs asynchronously with no valve glitch on deassertion; the first cycle after release re-evaluates from IDLE.

Verification
REQ-036 H=M=L=1, Us=0, T=1, 10 ticks, then Us=1 -> Vs=1, Bs=0, estado=1 for exactly 10 ticks, then estado=3 for 5 ticks, then estado=0.
REQ-037 Us held 0, Ua=1, T=0, L=1 -> Bs=1 for exactly 60 ticks (MAX_ON), then COOLDOWN; SPRAY re-entered after 5 ticks.
REQ-038 In DRIP at tempo=4, drop L=M=H=0 -> Vs=0 and Alarme=1 within 3 clk, estado=3; Ve=1.
REQ-039 H=1, M=0, L=1 for 2 ticks then valid -> no fault; same pattern for 3 ticks -> Erro=1, estado=4, Ve=Bs=Vs=0, held until reiniciar pulses low.
REQ-040 Levels L only -> Ve=1; raise M -> Ve stays 1; raise H -> Ve=0; drop H -> Ve stays 0 until M=0.
REQ-041 reiniciar low asynchronously mid-SPRAY (no clk edge) -> Bs=0 immediately, estado=0, tempo=0.
